// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC front end and control unit.
//   fetch_state_t     : instruction fetch FSM states
//   OPC_* / FUNCT_*   : instruction field positions (also used by the control unit)
//   INSTR_W           : instruction word width
//   DEFAULT_RESET_PC  : default PC loaded on reset
package kgp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  localparam int INSTR_W   = 32;
  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int FUNCT_MSB = 7;
  localparam int FUNCT_LSB = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter register for the fetch unit.
//   clk, rst      : clock, synchronous active-high reset (loads RESET_PC)
//   redirect_i    : load redirect_pc_i (word aligned); wins over incr_i
//   redirect_pc_i : redirect target, low two bits forced to zero
//   incr_i        : advance PC by 4, wrapping modulo 2^ADDR_W
//   pc_o          : current PC
module instruction_fetch_unit_pc_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      // Masking keeps the whole redirect bus in use while forcing word alignment.
      pc_d = redirect_pc_i & ~ADDR_W'(3);
    end else if (incr_i) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// KGP-RISC instruction fetch unit: holds the PC, fetches one word at a time
// over a req/gnt/rvalid handshake and presents it to the control unit.
//   clk, rst                          : clock, synchronous active-high reset
//   imem_req/imem_addr                : fetch request and word address (= pc)
//   imem_gnt/imem_rvalid/imem_rdata   : grant, response valid, response word
//   issue_ready                       : downstream consumes the presented word
//   redirect_valid/redirect_pc        : taken branch / jump target
//   instr_valid/instr/opCode/functCode: presented instruction and its fields
//   pc_out/pc_plus4                   : address of presented word and +4
module instruction_fetch_unit
  import kgp_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              imem_req,
  output logic [ADDR_W-1:0]                 imem_addr,
  input  logic                              imem_gnt,
  input  logic                              imem_rvalid,
  input  logic [INSTR_W-1:0]                imem_rdata,
  input  logic                              issue_ready,
  input  logic                              redirect_valid,
  input  logic [ADDR_W-1:0]                 redirect_pc,
  output logic                              instr_valid,
  output logic [INSTR_W-1:0]                instr,
  output logic [OPC_MSB-OPC_LSB:0]          opCode,
  output logic [FUNCT_MSB-FUNCT_LSB:0]      functCode,
  output logic [ADDR_W-1:0]                 pc_out,
  output logic [ADDR_W-1:0]                 pc_plus4
);

  fetch_state_t       state_q, state_d;
  logic               squash_q, squash_d;
  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [ADDR_W-1:0]  pc;
  logic               redirect_en;
  logic               incr_en;

  // Redirects are ignored while IDLE; everywhere else they reload the PC.
  assign redirect_en = redirect_valid && (state_q != ST_IDLE);

  instruction_fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_en),
    .redirect_pc_i (redirect_pc),
    .incr_i        (incr_en),
    .pc_o          (pc)
  );

  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    vld_d    = vld_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    incr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) begin
          state_d  = ST_WAIT;
          // A redirect in the grant cycle makes the just-issued fetch stale.
          squash_d = redirect_valid;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          // Same-cycle redirect stales this response just like an earlier one.
          if (squash_q || redirect_valid) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc;
            vld_d    = 1'b1;
            state_d  = ST_HOLD;
          end
        end else if (redirect_valid) begin
          squash_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // Redirect beats issue: no +4 is applied when both arrive together.
        if (redirect_valid) begin
          vld_d   = 1'b0;
          state_d = ST_REQ;
        end else if (issue_ready) begin
          incr_en = 1'b1;
          vld_d   = 1'b0;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      squash_q <= 1'b0;
      vld_q    <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      vld_q    <= vld_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc;
  assign instr_valid = vld_q;
  assign instr       = instr_q;
  assign opCode      = instr_q[OPC_MSB:OPC_LSB];
  assign functCode   = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + ADDR_W'(4);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        issue_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opCode;
  logic [7:0]  functCode;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  int tests_run;
  int tests_failed;

  instruction_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .issue_ready    (issue_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .opCode         (opCode),
    .functCode      (functCode),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Starts in REQ with imem_gnt=1; ends 1ns after the edge that enters HOLD.
  task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, " req"}, {31'd0, imem_req}, 32'd1);
    check({tag, " addr"}, imem_addr, addr);
    step();
    check({tag, " wait vld"}, {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    check({tag, " vld"}, {31'd0, instr_valid}, 32'd1);
    check({tag, " instr"}, instr, data);
    check({tag, " pc_out"}, pc_out, addr);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    issue_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    step();
    step();
    // Reset state
    check("rst req", {31'd0, imem_req}, 32'd0);
    check("rst addr", imem_addr, 32'h0);
    check("rst vld", {31'd0, instr_valid}, 32'd0);
    check("rst instr", instr, 32'h0);
    check("rst opCode", {26'd0, opCode}, 32'd0);
    check("rst functCode", {24'd0, functCode}, 32'd0);
    check("rst pc_out", pc_out, 32'h0);
    check("rst pc_plus4", pc_plus4, 32'h4);

    // Reset release and first fetch: cycle 1 IDLE, cycle 2 REQ, cycle 4 valid
    rst      = 1'b0;
    imem_gnt = 1'b1;
    check("idle req", {31'd0, imem_req}, 32'd0);
    step();
    fetch_one("first", 32'h0, 32'h2000_0020);
    check("first opCode", {26'd0, opCode}, {26'd0, 6'b001000});
    check("first functCode", {24'd0, functCode}, 32'h20);
    check("first pc_plus4", pc_plus4, 32'h4);

    // Sequential stream with issue_ready held high
    issue_ready = 1'b1;
    step();
    check("seq drop vld", {31'd0, instr_valid}, 32'd0);
    fetch_one("seq4", 32'h4, 32'h1111_0001);
    step();
    fetch_one("seq8", 32'h8, 32'h2222_0002);
    step();
    fetch_one("seq12", 32'hC, 32'h3333_0003);

    // Stall in HOLD for 5 cycles
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall vld", {31'd0, instr_valid}, 32'd1);
      check("stall req", {31'd0, imem_req}, 32'd0);
      check("stall instr", instr, 32'h3333_0003);
      check("stall pc_out", pc_out, 32'hC);
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    check("release vld", {31'd0, instr_valid}, 32'd0);
    check("release req", {31'd0, imem_req}, 32'd1);
    check("release addr", imem_addr, 32'h10);

    // Redirect while in WAIT squashes the in-flight response
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    check("squash wait req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0;
    check("squash vld", {31'd0, instr_valid}, 32'd0);
    fetch_one("redir", 32'h100, 32'h4444_0004);

    // Redirect and issue together in HOLD: redirect wins
    issue_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    issue_ready    = 1'b0;
    redirect_valid = 1'b0;
    check("both vld", {31'd0, instr_valid}, 32'd0);
    fetch_one("both", 32'h40, 32'h5555_0005);

    // Wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    fetch_one("top", 32'hFFFF_FFFC, 32'h6666_0006);
    check("top pc_plus4", pc_plus4, 32'h0);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    check("wrap addr", imem_addr, 32'h0);

    // Reset during WAIT, then a late response
    step();
    check("pre-rst wait req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    step();
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD1_BAD1;
    check("midrst vld", {31'd0, instr_valid}, 32'd0);
    check("midrst req", {31'd0, imem_req}, 32'd0);
    check("midrst pc", imem_addr, 32'h0);
    check("midrst pc_out", pc_out, 32'h0);
    check("midrst instr", instr, 32'h0);
    step();
    imem_rvalid = 1'b0;
    check("late vld", {31'd0, instr_valid}, 32'd0);
    check("late req", {31'd0, imem_req}, 32'd1);
    check("late addr", imem_addr, 32'h0);
    step();
    check("late wait vld", {31'd0, instr_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
